uart_tx: RTL and testbench

//  UART transmitter; the transmit counterpart of the UART receive path. Serialises one byte
//  per frame as start bit, 8 data bits LSB first, optional parity bit and stop bit. The bit

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, DATA_BITS LSB first, optional even parity (UART_TX_PARITY_EN), stop
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int CNT_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         tick_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shift;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    logic bit_end;
    logic stop_end;

    assign bit_end  = s_tick && (tick_cnt == CW'(OVERSAMPLE - 1));
    assign stop_end = s_tick && (tick_cnt == CW'(STOP_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with the accept edge is deliberately dropped.
                    if (tx_start) begin
                        shift      <= tx_data;
                        tick_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= START;
                        tx         <= 1'b0;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (stop_end) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a tick-count frame model
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int OS          = 16;
    localparam int FRAME_TICKS = (1 + 8 + P) * OS + 16;
    localparam int FW          = 10 + P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx;

    int n_vec = 0;
    int n_err = 0;
    int tick_period = 4;

    uart_tx dut (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_data(tx_data),
        .tx_start(tx_start), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tick_period == 0) begin
                s_tick = 1'b1;
            end else begin
                cnt = cnt + 1;
                if (cnt >= tick_period) begin
                    cnt = 0;
                    s_tick = 1'b1;
                end else begin
                    s_tick = 1'b0;
                end
            end
        end
    end

    // Model: a frame is just a tick count since accept mapped onto the bit list.
    logic       m_active;
    int         m_k;
    logic [7:0] m_byte;
    logic       m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
            m_byte   <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (tx_start) begin
                    m_active <= 1'b1;
                    m_k      <= 0;
                    m_byte   <= tx_data;
                end
            end else if (s_tick) begin
                if (m_k + 1 == FRAME_TICKS) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_k      <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_k / OS;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        if (P == 1 && b == 9) return ^m_byte;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("cyc_tx", {31'd0, tx}, {31'd0, exp_tx()});
            chk("cyc_ready", {31'd0, tx_ready}, {31'd0, !m_active});
            chk("cyc_busy", {31'd0, tx_busy}, {31'd0, m_active});
            chk("cyc_done", {31'd0, tx_done}, {31'd0, m_done});
        end
    end

    // Sends one byte, samples mid-bit and counts ticks to tx_done; optional injected
    // tx_start at a tick or reset at a tick.
    task automatic send(input string name, input logic [7:0] b, input logic [10:0] exp_frame,
                        input int inject_tick, input int reset_tick);
        int         ticks;
        int         cyc;
        logic [10:0] samp;
        logic       injected;
        logic       finished;
        ticks = 0;
        samp = '0;
        injected = 1'b0;
        finished = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        tx_start = 1'b0;
        for (cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(posedge clk);
            #2;
            if (injected) tx_start = 1'b0;
            if (s_tick) begin
                ticks = ticks + 1;
                if (ticks % OS == 8) samp[ticks/OS] = tx;
                if (ticks == inject_tick) begin
                    tx_data  = 8'hFF;
                    tx_start = 1'b1;
                    injected = 1'b1;
                end
                if (ticks == reset_tick) begin
                    rst_n = 1'b0;
                    #1;
                    chk({name, "_rst_tx"}, {31'd0, tx}, 32'd1);
                    chk({name, "_rst_ready"}, {31'd0, tx_ready}, 32'd1);
                    chk({name, "_rst_busy"}, {31'd0, tx_busy}, 32'd0);
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (tx_done) finished = 1'b1;
        end
        chk({name, "_finished"}, {31'd0, finished}, 32'd1);
        chk({name, "_ticks"}, ticks, FRAME_TICKS);
        chk({name, "_frame"}, {21'd0, samp}, {21'd0, exp_frame});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, tx_busy}, 32'd0);
        chk("reset_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        send("a5", 8'hA5, 11'b10_10100101_0, -1, -1);
        send("3c", 8'h3C, 11'b10_00111100_0, -1, -1);
        send("c3", 8'hC3, 11'b10_11000011_0, -1, -1);
        send("inj", 8'h00, 11'b10_00000000_0, 3 * OS + 4, -1);
        send("rst", 8'hA5, 11'b0, -1, 4 * OS + 4);
        send("55", 8'h55, 11'b10_01010101_0, -1, -1);
        send("07", 8'h07, 11'b11_00000111_0, -1, -1);
        send("03", 8'h03, 11'b10_00000011_0, -1, -1);
        tick_period = 0;
        send("hold", 8'hA5, 11'b10_10100101_0, -1, -1);
`else
        send("a5", 8'hA5, 11'b0_1_10100101_0, -1, -1);
        send("3c", 8'h3C, 11'b0_1_00111100_0, -1, -1);
        send("c3", 8'hC3, 11'b0_1_11000011_0, -1, -1);
        send("inj", 8'h00, 11'b0_1_00000000_0, 3 * OS + 4, -1);
        send("rst", 8'hA5, 11'b0, -1, 4 * OS + 4);
        send("55", 8'h55, 11'b0_1_01010101_0, -1, -1);
        tick_period = 0;
        send("hold", 8'hA5, 11'b0_1_10100101_0, -1, -1);
`endif
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
